tc_mem_port_arbiter: RTL and testbench



---
 rtl/tc_mem_arb_pkg.sv | 33 +++
 rtl/tc_mem_arb_tag_pipe.sv | 34 +++
 rtl/tc_mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_tc_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_mem_arb_pkg.sv
// Shared types and constants for the tightly-coupled memory port-A arbiter.
// The request bundle matches the default port-A geometry (8192 x 32, byte-enabled).
package tc_mem_arb_pkg;

    localparam int unsigned ARB_ADDR_W       = 13;
    localparam int unsigned ARB_DATA_W       = 32;
    localparam int unsigned ARB_BE_W         = ARB_DATA_W / 8;
    localparam int unsigned MAX_READ_LATENCY = 4;
    localparam int unsigned HOLD_W           = 4;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_BE_W-1:0]   be;
        logic [ARB_DATA_W-1:0] wdata;
        logic                  write;
    } mem_req_t;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_entry_t;

    function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] v);
        logic [HOLD_W-1:0] r;
        if (v == {HOLD_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(HOLD_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/tc_mem_arb_tag_pipe.sv
// Latency-matched shift register of read tags; the last stage tells which
// requester owns the data currently on mem_readdata.
module tc_mem_arb_tag_pipe
    import tc_mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  tag_entry_t push,
    output logic       s0_valid,
    output logic       s1_valid
);

    tag_entry_t stage_r [DEPTH];

    // Shift tags one stage per cycle; reset drops every in-flight read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_r[i] <= '{valid: 1'b0, id: 1'b0};
            end
        end else begin
            stage_r[0] <= push;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign s0_valid = stage_r[DEPTH-1].valid & (stage_r[DEPTH-1].id == 1'b0);
    assign s1_valid = stage_r[DEPTH-1].valid & (stage_r[DEPTH-1].id == 1'b1);

endmodule

// File: rtl/tc_mem_port_arbiter.sv
// Round-robin, zero-wait arbiter sharing memory port A between two Avalon-MM
// requesters, with a bounded hold count and tagged in-order read return.
module tc_mem_port_arbiter
    import tc_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = ARB_ADDR_W,
    parameter int unsigned DATA_W       = ARB_DATA_W,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_HOLD     = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   s0_address,
    input  logic [DATA_W/8-1:0] s0_byteenable,
    input  logic                s0_read,
    input  logic                s0_write,
    input  logic [DATA_W-1:0]   s0_writedata,
    output logic                s0_waitrequest,
    output logic [DATA_W-1:0]   s0_readdata,
    output logic                s0_readdatavalid,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic                s1_waitrequest,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

    logic              owner_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              req0_s;
    logic              req1_s;
    logic              grant_s;
    logic              winner_s;
    mem_req_t          bundle0_s;
    mem_req_t          bundle1_s;
    mem_req_t          sel_s;
    tag_entry_t        push_s;

    // Winner selection: the owner keeps the port until its hold budget runs out.
    always_comb begin
        req0_s   = s0_read | s0_write;
        req1_s   = s1_read | s1_write;
        grant_s  = 1'b0;
        winner_s = 1'b0;
        if (!reset_n) begin
            grant_s  = 1'b0;
            winner_s = 1'b0;
        end else if (req0_s && req1_s) begin
            grant_s  = 1'b1;
            winner_s = (hold_cnt_r < HOLD_LIMIT) ? owner_r : ~owner_r;
        end else if (req0_s) begin
            grant_s  = 1'b1;
            winner_s = 1'b0;
        end else if (req1_s) begin
            grant_s  = 1'b1;
            winner_s = 1'b1;
        end else begin
            grant_s  = 1'b0;
            winner_s = 1'b0;
        end
    end

    // Command mux; an idle port parks on s0's fields with chipselect low.
    always_comb begin
        bundle0_s = '{addr: s0_address, be: s0_byteenable, wdata: s0_writedata, write: s0_write};
        bundle1_s = '{addr: s1_address, be: s1_byteenable, wdata: s1_writedata, write: s1_write};
        if (grant_s && winner_s) begin
            sel_s = bundle1_s;
        end else begin
            sel_s = bundle0_s;
        end
        mem_address    = sel_s.addr;
        mem_byteenable = sel_s.be;
        mem_writedata  = sel_s.wdata;
        mem_write      = grant_s & sel_s.write;
        mem_chipselect = grant_s;
        s0_waitrequest = ~(grant_s & ~winner_s);
        s1_waitrequest = ~(grant_s & winner_s);
        push_s         = '{valid: grant_s & ~sel_s.write, id: winner_s};
    end

    // Ownership and hold-count tracking, updated only on granted cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_r    <= 1'b0;
            hold_cnt_r <= {HOLD_W{1'b0}};
        end else if (grant_s) begin
            if (winner_s == owner_r) begin
                owner_r    <= owner_r;
                hold_cnt_r <= hold_sat_inc(hold_cnt_r);
            end else begin
                owner_r    <= winner_s;
                hold_cnt_r <= {HOLD_W{1'b0}};
            end
        end else begin
            owner_r    <= owner_r;
            hold_cnt_r <= hold_cnt_r;
        end
    end

    tc_mem_arb_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push_s),
        .s0_valid (s0_readdatavalid),
        .s1_valid (s1_readdatavalid)
    );

    assign s0_readdata = mem_readdata;
    assign s1_readdata = mem_readdata;

endmodule

// File: tb/tb_tc_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level reference model of arbitration, memory and read return.
module tb_tc_mem_port_arbiter;

    localparam int ADDR_W   = 13;
    localparam int DATA_W   = 32;
    localparam int BE_W     = 4;
    localparam int RL       = 3;
    localparam int MAX_HOLD = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] s0_address, s1_address, mem_address;
    logic [BE_W-1:0]   s0_byteenable, s1_byteenable, mem_byteenable;
    logic              s0_read, s0_write, s1_read, s1_write;
    logic [DATA_W-1:0] s0_writedata, s1_writedata, mem_writedata, mem_readdata;
    logic              s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid;
    logic [DATA_W-1:0] s0_readdata, s1_readdata;
    logic              mem_chipselect, mem_write;

    always #5 clk = ~clk;

    tc_mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s0_address(s0_address), .s0_byteenable(s0_byteenable), .s0_read(s0_read),
        .s0_write(s0_write), .s0_writedata(s0_writedata), .s0_waitrequest(s0_waitrequest),
        .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_read(s1_read),
        .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_waitrequest(s1_waitrequest),
        .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
    );

    function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // Memory behind port A, driven only by the DUT's mem_* pins.
    logic [31:0] env_mem [8192];
    logic [31:0] env_rd_r [RL];
    always @(posedge clk) begin
        if (mem_chipselect && mem_write)
            env_mem[mem_address] <= be_merge(env_mem[mem_address], mem_writedata, mem_byteenable);
        env_rd_r[0] <= (mem_chipselect && !mem_write) ? env_mem[mem_address] : 32'h0BAD0BAD;
        for (int i = 1; i < RL; i++) env_rd_r[i] <= env_rd_r[i-1];
    end
    assign mem_readdata = env_rd_r[RL-1];

    // Reference model state
    typedef struct {
        int          due;
        bit          id;
        logic [31:0] data;
        bit          known;
    } pend_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          ref_owner;
    int          ref_hold;
    logic [31:0] ref_mem [8192];
    bit          ref_known [8192];
    pend_t       pend_q [$];
    int          gnt0_cnt, gnt1_cnt, rdv0_cnt, rdv1_cnt;
    logic [31:0] last_rd0, last_rd1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: check outputs against the model, then advance the model.
    task automatic step();
        bit r0, r1, g, w, wr, ev0, ev1;
        logic [ADDR_W-1:0] a;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wd;
        pend_t             p;
        #1;
        if (!reset_n) begin
            ref_owner = 1'b0;
            ref_hold  = 0;
            pend_q.delete();
        end
        r0 = s0_read | s0_write;
        r1 = s1_read | s1_write;
        g  = 1'b0;
        w  = 1'b0;
        if (reset_n && (r0 || r1)) begin
            g = 1'b1;
            if (r0 && r1) w = (ref_hold < MAX_HOLD - 1) ? ref_owner : !ref_owner;
            else          w = r1;
        end
        wr = w ? s1_write : s0_write;
        a  = w ? s1_address : s0_address;
        be = w ? s1_byteenable : s0_byteenable;
        wd = w ? s1_writedata : s0_writedata;
        check_eq("s0_waitrequest", s0_waitrequest, !(g && !w));
        check_eq("s1_waitrequest", s1_waitrequest, !(g && w));
        check_eq("mem_chipselect", mem_chipselect, g);
        check_eq("mem_write", mem_write, g && wr);
        check_eq("mem_address", mem_address, a);
        if (g) check_eq("mem_byteenable", mem_byteenable, be);
        if (g && wr) check_eq("mem_writedata", mem_writedata, wd);

        ev0 = 1'b0;
        ev1 = 1'b0;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            p = pend_q.pop_front();
            if (p.id) ev1 = 1'b1;
            else      ev0 = 1'b1;
            if (p.known) begin
                if (p.id) check_eq("s1_readdata", s1_readdata, p.data);
                else      check_eq("s0_readdata", s0_readdata, p.data);
            end
        end
        check_eq("s0_readdatavalid", s0_readdatavalid, ev0);
        check_eq("s1_readdatavalid", s1_readdatavalid, ev1);
        if (s0_readdatavalid) begin rdv0_cnt++; last_rd0 = s0_readdata; end
        if (s1_readdatavalid) begin rdv1_cnt++; last_rd1 = s1_readdata; end
        if (!s0_waitrequest) gnt0_cnt++;
        if (!s1_waitrequest) gnt1_cnt++;

        @(posedge clk);
        if (reset_n && g) begin
            if (wr) begin
                ref_mem[a] = be_merge(ref_mem[a], wd, be);
                if (be == 4'hF) ref_known[a] = 1'b1;
            end else begin
                pend_q.push_back('{due: cyc + RL, id: w, data: ref_mem[a], known: ref_known[a]});
            end
            if (w == ref_owner) begin
                if (ref_hold < 15) ref_hold++;
            end else begin
                ref_owner = w;
                ref_hold  = 0;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        s0_read = 1'b0; s0_write = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    endtask

    task automatic drain(input int n);
        idle();
        repeat (n) step();
    endtask

    task automatic clear_counts();
        gnt0_cnt = 0; gnt1_cnt = 0; rdv0_cnt = 0; rdv1_cnt = 0;
        last_rd0 = 32'h0; last_rd1 = 32'h0;
    endtask

    initial begin
        idle();
        s0_address = 13'h0055; s0_byteenable = 4'hF; s0_writedata = 32'h0;
        s1_address = 13'h0000; s1_byteenable = 4'hF; s1_writedata = 32'h0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        clear_counts();
        @(negedge clk);

        // Reset holds the port closed even with a pending request
        s0_read = 1'b1;
        step();
        step();
        check_eq("rst_wait0", s0_waitrequest, 1'b1);
        check_eq("rst_cs", mem_chipselect, 1'b0);
        reset_n = 1'b1;
        #1;
        check_eq("rel_wait0", s0_waitrequest, 1'b0);
        check_eq("rel_addr", mem_address, 13'h0055);
        step();
        drain(RL + 1);

        // Single-port write then read
        clear_counts();
        s0_write = 1'b1; s0_address = 13'h0010; s0_writedata = 32'hDEADBEEF; s0_byteenable = 4'hF;
        step();
        idle(); s0_read = 1'b1;
        step();
        drain(RL + 1);
        check_eq("single_rdv0_cnt", rdv0_cnt, 1);
        check_eq("single_rdv1_cnt", rdv1_cnt, 0);
        check_eq("single_data", last_rd0, 32'hDEADBEEF);

        // Contention fairness from a freshly reset arbiter
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        clear_counts();
        s0_read = 1'b1; s0_address = 13'h0010;
        s1_read = 1'b1; s1_address = 13'h0010;
        repeat (16) step();
        drain(RL + 1);
        check_eq("fair_gnt0", gnt0_cnt, 8);
        check_eq("fair_gnt1", gnt1_cnt, 8);
        check_eq("fair_rdv0", rdv0_cnt, 8);
        check_eq("fair_rdv1", rdv1_cnt, 8);

        // Byte-enabled write at the top address
        clear_counts();
        s1_write = 1'b1; s1_address = 13'h1FFF; s1_writedata = 32'hFFFFFFFF; s1_byteenable = 4'hF;
        step();
        s1_writedata = 32'h11223344; s1_byteenable = 4'h5;
        step();
        idle(); s1_read = 1'b1;
        step();
        drain(RL + 1);
        check_eq("be_rdv1_cnt", rdv1_cnt, 1);
        check_eq("be_data", last_rd1, 32'hFF22FF44);

        // Reset while reads are in flight
        clear_counts();
        s0_read = 1'b1; s0_address = 13'h0010;
        step();
        step();
        idle();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        drain(RL + 2);
        check_eq("midrst_rdv0", rdv0_cnt, 0);
        s0_read = 1'b1; s0_address = 13'h1FFF;
        step();
        drain(RL + 1);
        check_eq("postrst_rdv0", rdv0_cnt, 1);
        check_eq("postrst_data", last_rd0, 32'hFF22FF44);

        // Read and write together are a write
        clear_counts();
        s0_read = 1'b1; s0_write = 1'b1; s0_address = 13'h0100;
        s0_writedata = 32'hA5A5A5A5; s0_byteenable = 4'hF;
        #1;
        check_eq("rw_mem_write", mem_write, 1'b1);
        step();
        drain(RL + 1);
        check_eq("rw_no_rdv", rdv0_cnt, 0);
        s0_read = 1'b1;
        step();
        drain(RL + 1);
        check_eq("rw_data", last_rd0, 32'hA5A5A5A5);

        // Preload a small address window, then random traffic over it
        for (int i = 0; i < 16; i++) begin
            idle();
            s0_write = 1'b1; s0_address = ADDR_W'(i); s0_byteenable = 4'hF; s0_writedata = $urandom;
            step();
        end
        for (int n = 0; n < 600; n++) begin
            s0_read = 1'($urandom_range(0, 1)); s0_write = 1'($urandom_range(0, 2) == 0);
            s1_read = 1'($urandom_range(0, 1)); s1_write = 1'($urandom_range(0, 2) == 0);
            s0_address = ADDR_W'($urandom_range(0, 15)); s1_address = ADDR_W'($urandom_range(0, 15));
            s0_byteenable = 4'($urandom); s1_byteenable = 4'($urandom);
            s0_writedata = $urandom; s1_writedata = $urandom;
            reset_n = ($urandom_range(0, 99) != 0);
            step();
            reset_n = 1'b1;
        end
        drain(RL + 2);
        check_eq("pending_empty", pend_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
